spi_fpga_master_sequencer: RTL and testbench
============================================

# spi_fpga_master_sequencer

Front-end stage placed directly upstream of `SPI_FPGA_MASTER`: it buffers transmit words in a TX FIFO and issues one SPI pack per word. For each word it drives the master's data and launch inputs, tracks chip-select and completion, and stores the received pack in an RX FIFO. The block removes per-pack handshaking from the host logic and keeps back-to-back transfers spaced by a programmable idle gap.

## Interface
Parameters:
- `PACK_LENGTH`, 8: bits per SPI pack; matches the master.
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, ≥2.
- `LAUNCH_HOLD_CLOCKS`, 5: `OUT_LAUNCH` stays high this many clocks after CS is first sampled low.
- `GAP_CLOCKS`, 4: idle clocks between a capture and the next load; 0 is legal.

Ports:
- `IN_CLOCK`  in  1  single system clock; all logic on its rising edge.
- `IN_RESET`  in  1  synchronous, active-high reset.
- `IN_WRITE`  in  1  push `IN_DATA` into the TX FIFO.
- `IN_DATA`  in  PACK_LENGTH  transmit word.
- `IN_READ`  in  1  pop the RX FIFO head.
- `OUT_RX_DATA`  out  PACK_LENGTH  RX FIFO head (first-word fall-through).
- `OUT_TX_FULL` / `OUT_RX_EMPTY`  out  1 each  FIFO flags.
- `OUT_TX_OVERFLOW` / `OUT_RX_OVERFLOW`  out  1 each  sticky drop flags.
- `OUT_BUSY`  out  1  high in any state other than IDLE.
- `OUT_MASTER_DATA`  out  PACK_LENGTH  to master `IN_MASTER_DATA`.
- `OUT_LAUNCH`  out  1  to master `IN_LAUNCH`.
- `IN_MASTER_CS`  in  1  master CS (active low).
- `IN_MASTER_ACTION_DONE`  in  1  master completion.
- `IN_MASTER_RECEIVE_DATA`  in  PACK_LENGTH  master received pack.

## Operation
- The TX and RX FIFOs are circular buffers with `$clog2(FIFO_DEPTH)`-bit pointers that wrap naturally. Occupancy counters are `$clog2(FIFO_DEPTH)+1` bits wide.
- A write while full is dropped and sets `OUT_TX_OVERFLOW`. A read while empty is ignored.
- A push and a pop on the same FIFO in the same cycle are both performed. The full and empty flags then stay unchanged.
- FSM states: IDLE → LOAD → LAUNCH → WAIT_DONE → CAPTURE → GAP → IDLE.
  - IDLE: when the TX FIFO is not empty, move to LOAD.
  - LOAD: register the TX head into `OUT_MASTER_DATA` and pop it. Move to LAUNCH.
  - LAUNCH: `OUT_LAUNCH`=1. Count starts on the first cycle `IN_MASTER_CS`=0 is sampled. After `LAUNCH_HOLD_CLOCKS` counted cycles, drop `OUT_LAUNCH` and move to WAIT_DONE.
  - WAIT_DONE: wait for a 0→1 edge on `IN_MASTER_ACTION_DONE`, detected against a registered copy. A level that is already high on entry does not count.
  - CAPTURE: push `IN_MASTER_RECEIVE_DATA` into the RX FIFO. If the RX FIFO is full, drop the word and set `OUT_RX_OVERFLOW`. Move to GAP.
  - GAP: count `GAP_CLOCKS`, then return to IDLE. With `GAP_CLOCKS`=0, GAP lasts one cycle.
- `OUT_MASTER_DATA` holds its value from LOAD until the next LOAD.
- A done edge outside WAIT_DONE is ignored.
- Reset mid-transfer: the FSM goes to IDLE, `OUT_LAUNCH` drops, and both FIFOs are flushed. The master's in-flight pack is abandoned, and the host must also reset the master.

## Timing
- Reset values:
  - `OUT_MASTER_DATA`=0, `OUT_LAUNCH`=0, `OUT_BUSY`=0.
  - `OUT_TX_FULL`=0, `OUT_RX_EMPTY`=1.
  - Both overflow flags =0.
  - `OUT_RX_DATA`=0, since the RX storage is cleared on reset.
- Write into an empty TX FIFO with the FSM in IDLE:
  - edge N: word stored;
  - N+1: LOAD;
  - N+2: `OUT_MASTER_DATA` valid and `OUT_LAUNCH`=1.
  Data is therefore stable at least one clock before launch.
- Capture: the RX word is visible on `OUT_RX_DATA` one clock after the CAPTURE edge.
- All flags are registered and update on the edge that changes occupancy.
- Overflow flags are cleared only by `IN_RESET`.

## Configuration
- `SPI_SEQ_RX_FIFO_EN` defined: RX path as described above (FIFO, `IN_READ`, `OUT_RX_EMPTY`, `OUT_RX_OVERFLOW`).
- `SPI_SEQ_RX_FIFO_EN` undefined:
  - CAPTURE writes a single register driven on `OUT_RX_DATA`; each new pack overwrites it.
  - `OUT_RX_EMPTY` goes low on the first capture and returns high on `IN_READ`.
  - `IN_READ` otherwise has no effect.
  - `OUT_RX_OVERFLOW` is tied to 0.
  - The TX path is unchanged.

## Test plan
- Reset → `OUT_LAUNCH`=0, `OUT_BUSY`=0, `OUT_RX_EMPTY`=1, `OUT_TX_FULL`=0.
- Write 8'b11101010 while slave transmits 8'b01010011 (loop through master/slave, CPOL=CPHA=1):
  - `OUT_MASTER_DATA`=8'hEA two clocks after the write;
  - `OUT_LAUNCH` high until 5 clocks after CS falls;
  - RX head = slave pack as received by master;
  - `OUT_BUSY` low after GAP.
- Write 3 words back-to-back → exactly 3 launches in FIFO order, each separated by ≥`GAP_CLOCKS` idle clocks; RX count = 3.
- Fill TX with 16 words and write a 17th → `OUT_TX_FULL`=1, `OUT_TX_OVERFLOW`=1, and the 17th word is never transmitted.
- Complete 17 packs with no `IN_READ` → the 17th capture is dropped, `OUT_RX_OVERFLOW`=1, and the RX head is still pack 1.
- Assert `IN_RESET` during WAIT_DONE → next clock state IDLE, `OUT_LAUNCH`=0, both FIFOs empty; a later done edge is ignored.

Source files
------------

// File: rtl/spi_fpga_master_sequencer.sv
// Sequencer in front of SPI_FPGA_MASTER: TX FIFO -> one pack per word -> RX storage.
// Define SPI_SEQ_RX_FIFO_EN for an RX FIFO; otherwise RX is a single overwrite register.
module spi_fpga_master_sequencer #(
    parameter int PACK_LENGTH        = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int LAUNCH_HOLD_CLOCKS = 5,
    parameter int GAP_CLOCKS         = 4
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET,
    input  logic                   IN_WRITE,
    input  logic [PACK_LENGTH-1:0] IN_DATA,
    input  logic                   IN_READ,
    output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
    output logic                   OUT_TX_FULL,
    output logic                   OUT_RX_EMPTY,
    output logic                   OUT_TX_OVERFLOW,
    output logic                   OUT_RX_OVERFLOW,
    output logic                   OUT_BUSY,
    output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
    output logic                   OUT_LAUNCH,
    input  logic                   IN_MASTER_CS,
    input  logic                   IN_MASTER_ACTION_DONE,
    input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (LAUNCH_HOLD_CLOCKS > 0) ? $clog2(LAUNCH_HOLD_CLOCKS + 1) : 1;
    localparam int GW = (GAP_CLOCKS > 0) ? $clog2(GAP_CLOCKS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_CAPT, S_GAP
    } state_t;

    state_t state_q;
    logic [PACK_LENGTH-1:0] mdata_q;
    logic launch_q, busy_q, cs_seen_q, done_q;
    logic [HW-1:0] hold_q;
    logic [GW-1:0] gap_q;
    logic capture;

    logic [PACK_LENGTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic tx_full_q, tx_empty_q, tx_ovf_q, tx_push, tx_pop;

    assign tx_push  = IN_WRITE && !tx_full_q;
    assign tx_pop   = (state_q == S_LOAD);
    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign capture  = (state_q == S_CAPT);

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_empty_q <= 1'b1;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            tx_cnt_q   <= tx_cnt_d;
            tx_full_q  <= (tx_cnt_d == CW'(FIFO_DEPTH));
            tx_empty_q <= (tx_cnt_d == '0);
            if (IN_WRITE && tx_full_q) tx_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= IN_DATA;
    end

    // done_q tracks the level every cycle so a high level on WAIT entry is not an edge
    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state_q   <= S_IDLE;
            mdata_q   <= '0;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            cs_seen_q <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= '0;
            gap_q     <= '0;
        end else begin
            done_q <= IN_MASTER_ACTION_DONE;
            unique case (state_q)
                S_IDLE: begin
                    if (!tx_empty_q) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    mdata_q   <= tx_mem_q[tx_rd_q];
                    launch_q  <= 1'b1;
                    hold_q    <= '0;
                    cs_seen_q <= 1'b0;
                    state_q   <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    if (cs_seen_q || !IN_MASTER_CS) begin
                        cs_seen_q <= 1'b1;
                        if (hold_q == HW'(LAUNCH_HOLD_CLOCKS - 1)) begin
                            launch_q <= 1'b0;
                            state_q  <= S_WAIT;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (IN_MASTER_ACTION_DONE && !done_q) state_q <= S_CAPT;
                end
                S_CAPT: begin
                    gap_q   <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (GAP_CLOCKS <= 1 || gap_q == GW'(GAP_CLOCKS - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_SEQ_RX_FIFO_EN
    logic [PACK_LENGTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic rx_full_q, rx_empty_q, rx_ovf_q, rx_push, rx_pop;

    assign rx_push  = capture && !rx_full_q;
    assign rx_pop   = IN_READ && !rx_empty_q;
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            rx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            rx_ovf_q   <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wr_q] <= IN_MASTER_RECEIVE_DATA;
                rx_wr_q <= rx_wr_q + AW'(1);
            end
            if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
            rx_cnt_q   <= rx_cnt_d;
            rx_full_q  <= (rx_cnt_d == CW'(FIFO_DEPTH));
            rx_empty_q <= (rx_cnt_d == '0);
            if (capture && rx_full_q) rx_ovf_q <= 1'b1;
        end
    end

    assign OUT_RX_DATA     = rx_mem_q[rx_rd_q];
    assign OUT_RX_EMPTY    = rx_empty_q;
    assign OUT_RX_OVERFLOW = rx_ovf_q;
`else
    logic [PACK_LENGTH-1:0] rx_reg_q;
    logic rx_empty_q;

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            rx_reg_q   <= '0;
            rx_empty_q <= 1'b1;
        end else if (capture) begin
            rx_reg_q   <= IN_MASTER_RECEIVE_DATA;
            rx_empty_q <= 1'b0;
        end else if (IN_READ) begin
            rx_empty_q <= 1'b1;
        end
    end

    assign OUT_RX_DATA     = rx_reg_q;
    assign OUT_RX_EMPTY    = rx_empty_q;
    assign OUT_RX_OVERFLOW = 1'b0;
`endif

    assign OUT_TX_FULL     = tx_full_q;
    assign OUT_TX_OVERFLOW = tx_ovf_q;
    assign OUT_BUSY        = busy_q;
    assign OUT_MASTER_DATA = mdata_q;
    assign OUT_LAUNCH      = launch_q;
endmodule

// File: tb/tb_spi_fpga_master_sequencer.sv
// Bench for spi_fpga_master_sequencer: emulates the SPI master at transaction level
// and checks against queue models of the TX and RX paths.
module tb_spi_fpga_master_sequencer;
    localparam int PL    = 8;
    localparam int DEPTH = 16;
    localparam int HOLD  = 5;
    localparam int GAP   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, wr = 1'b0, rd = 1'b0, cs = 1'b1, done = 1'b0;
    logic [PL-1:0] din = '0, mrx = '0;
    logic [PL-1:0] rx_data, m_data;
    logic tx_full, rx_empty, tx_ovf, rx_ovf, busy, launch;

    int tests = 0, fails = 0, cyc = 0, last_done = -1000;
    logic [PL-1:0] tx_q[$];
    logic [PL-1:0] rx_q[$];
    logic [PL-1:0] rx_last = '0;
    bit rx_has = 0;
    bit rx_ovf_exp = 0;

    spi_fpga_master_sequencer #(
        .PACK_LENGTH(PL), .FIFO_DEPTH(DEPTH),
        .LAUNCH_HOLD_CLOCKS(HOLD), .GAP_CLOCKS(GAP)
    ) dut (
        .IN_CLOCK(clk), .IN_RESET(rst), .IN_WRITE(wr), .IN_DATA(din),
        .IN_READ(rd), .OUT_RX_DATA(rx_data), .OUT_TX_FULL(tx_full),
        .OUT_RX_EMPTY(rx_empty), .OUT_TX_OVERFLOW(tx_ovf),
        .OUT_RX_OVERFLOW(rx_ovf), .OUT_BUSY(busy),
        .OUT_MASTER_DATA(m_data), .OUT_LAUNCH(launch),
        .IN_MASTER_CS(cs), .IN_MASTER_ACTION_DONE(done),
        .IN_MASTER_RECEIVE_DATA(mrx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [PL-1:0] w, input bit keep);
        wr = 1'b1;
        din = w;
        @(posedge clk);
        #1 wr = 1'b0;
        if (keep) tx_q.push_back(w);
    endtask

    task automatic serve_pack(input logic [PL-1:0] slave);
        int n;
        int hi;
        logic [PL-1:0] exp;
        n = 0;
        @(negedge clk);
        while (launch !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (launch !== 1'b1) begin
            fails++;
            $display("FAIL launch_timeout got=%b want=1", launch);
            return;
        end
        tests++;
        if (tx_q.size() == 0) begin
            fails++;
            $display("FAIL launch_order got=%h want=no_launch", m_data);
        end else begin
            exp = tx_q.pop_front();
            if (m_data !== exp) begin
                fails++;
                $display("FAIL launch_order got=%h want=%h", m_data, exp);
            end
        end
        tests++;
        if (cyc - last_done < GAP + 2) begin
            fails++;
            $display("FAIL gap_spacing got=%0d want>=%0d", cyc - last_done, GAP + 2);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 cs = 1'b0;
        hi = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (launch !== 1'b1 || n > 50) break;
            hi++;
            n++;
        end
        tests++;
        if (hi != HOLD) begin
            fails++;
            $display("FAIL launch_hold got=%0d want=%0d", hi, HOLD);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 mrx = slave;
        done = 1'b1;
        last_done = cyc;
        repeat (2) @(posedge clk);
        #1 done = 1'b0;
        cs = 1'b1;
`ifdef SPI_SEQ_RX_FIFO_EN
        if (rx_q.size() < DEPTH) rx_q.push_back(slave);
        else rx_ovf_exp = 1;
`else
        rx_last = slave;
        rx_has = 1;
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_timeout got=%b want=0", busy);
        end
    endtask

    task automatic drain_rx();
`ifdef SPI_SEQ_RX_FIFO_EN
        while (rx_q.size() > 0) begin
            @(negedge clk);
            tests++;
            if (rx_data !== rx_q[0] || rx_empty !== 1'b0) begin
                fails++;
                $display("FAIL rx_head got=%h/%b want=%h/0", rx_data, rx_empty, rx_q[0]);
            end
            void'(rx_q.pop_front());
            @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
        end
`else
        if (rx_has) begin
            @(negedge clk);
            tests++;
            if (rx_data !== rx_last || rx_empty !== 1'b0) begin
                fails++;
                $display("FAIL rx_reg got=%h/%b want=%h/0", rx_data, rx_empty, rx_last);
            end
            @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
            rx_has = 0;
        end
`endif
        @(negedge clk);
        tests++;
        if (rx_empty !== 1'b1) begin
            fails++;
            $display("FAIL rx_drained got=%b want=1", rx_empty);
        end
    endtask

    task automatic check_stays_idle(input string name);
        bit bad;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || launch !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s got=busy_or_launch want=idle", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (launch !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b%b want=00", launch, busy);
        end
        tests++;
        if (rx_empty !== 1'b1 || tx_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b%b want=10", rx_empty, tx_full);
        end
        tests++;
        if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf got=%b%b want=00", tx_ovf, rx_ovf);
        end
        tests++;
        if (m_data !== '0 || rx_data !== '0) begin
            fails++;
            $display("FAIL reset_data got=%h/%h want=00/00", m_data, rx_data);
        end
        @(posedge clk);
        #1 done = 1'b1;
        repeat (2) @(posedge clk);
        #1 done = 1'b0;
        check_stays_idle("done_in_idle");
        tests++;
        if (rx_empty !== 1'b1) begin
            fails++;
            $display("FAIL done_in_idle_rx got=%b want=1", rx_empty);
        end
    endtask

    task automatic test_single();
        @(posedge clk);
        #1 push_word(8'hEA, 1);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || launch !== 1'b0) begin
            fails++;
            $display("FAIL single_load got=%b%b want=10", busy, launch);
        end
        @(negedge clk);
        tests++;
        if (launch !== 1'b1 || m_data !== 8'hEA) begin
            fails++;
            $display("FAIL single_launch got=%b/%h want=1/ea", launch, m_data);
        end
        serve_pack(8'h53);
        wait_idle();
        tests++;
        if (rx_data !== 8'h53 || rx_empty !== 1'b0) begin
            fails++;
            $display("FAIL single_rx got=%h/%b want=53/0", rx_data, rx_empty);
        end
        drain_rx();
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_word(PL'($urandom), 1);
        for (int i = 0; i < 3; i++) serve_pack(PL'($urandom));
        wait_idle();
        tests++;
        if (tx_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=0 pending", tx_q.size());
        end
        check_stays_idle("b2b_extra_launch");
        drain_rx();
    endtask

    task automatic test_overflow();
        logic [PL-1:0] first;
        int n;
        @(posedge clk);
        #1 push_word(PL'($urandom), 1);
        n = 0;
        while (launch !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) push_word(PL'($urandom), 1);
        tests++;
        if (tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
            fails++;
            $display("FAIL tx_full got=%b/%b want=1/0", tx_full, tx_ovf);
        end
        push_word(PL'($urandom), 0);
        tests++;
        if (tx_full !== 1'b1 || tx_ovf !== 1'b1) begin
            fails++;
            $display("FAIL tx_overflow got=%b/%b want=1/1", tx_full, tx_ovf);
        end
        first = PL'($urandom);
        serve_pack(first);
        for (int i = 0; i < DEPTH; i++) serve_pack(PL'($urandom));
        wait_idle();
        check_stays_idle("tx_dropped_word_sent");
        tests++;
        if (tx_ovf !== 1'b1 || tx_full !== 1'b0) begin
            fails++;
            $display("FAIL tx_ovf_sticky got=%b/%b want=1/0", tx_ovf, tx_full);
        end
        tests++;
`ifdef SPI_SEQ_RX_FIFO_EN
        if (rx_ovf !== rx_ovf_exp || rx_data !== first) begin
            fails++;
            $display("FAIL rx_overflow got=%b/%h want=%b/%h", rx_ovf, rx_data, rx_ovf_exp, first);
        end
`else
        if (rx_ovf !== 1'b0 || rx_data !== rx_last) begin
            fails++;
            $display("FAIL rx_overwrite got=%b/%h want=0/%h", rx_ovf, rx_data, rx_last);
        end
`endif
        drain_rx();
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        @(posedge clk);
        #1 push_word(PL'($urandom), 0);
        n = 0;
        while (launch !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cs = 1'b0;
        n = 0;
        while (launch !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        push_word(PL'($urandom), 0);
        push_word(PL'($urandom), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        rx_has = 0;
        rx_ovf_exp = 0;
        @(negedge clk);
        tests++;
        if (launch !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            fails++;
            $display("FAIL midreset_ctrl got=%b%b/%h want=00/00", launch, busy, m_data);
        end
        tests++;
        if (rx_empty !== 1'b1 || tx_full !== 1'b0 || tx_ovf !== 1'b0) begin
            fails++;
            $display("FAIL midreset_flags got=%b%b%b want=100", rx_empty, tx_full, tx_ovf);
        end
        cs = 1'b1;
        @(posedge clk);
        #1 done = 1'b1;
        repeat (2) @(posedge clk);
        #1 done = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || rx_empty !== 1'b1) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL midreset_flush got=%b%b want=01", busy, rx_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
